// File: rtl/range_tracker_pkg.sv
// Shared types and helpers for the window range tracker.
package range_tracker_pkg;

    typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} rt_state_t;

    // Counter must hold 0..N-1 with headroom for the close compare.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/window_range_tracker_mm_merge.sv
// Combinational fold of one (min, max) pair into the running window accumulators.
module mm_merge #(
    parameter int w = 2
) (
    input  logic [w-1:0] acc_min,
    input  logic [w-1:0] acc_max,
    input  logic [w-1:0] in_min,
    input  logic [w-1:0] in_max,
    input  logic         first,
    output logic [w-1:0] mrg_min,
    output logic [w-1:0] mrg_max,
    output logic         pair_err
);

    always_comb begin
        pair_err = in_min > in_max;
        // First pair of a window loads directly so stale accumulators never leak in.
        if (first) begin
            mrg_min = in_min;
            mrg_max = in_max;
        end else begin
            mrg_min = (in_min < acc_min) ? in_min : acc_min;
            mrg_max = (in_max > acc_max) ? in_max : acc_max;
        end
    end

endmodule

// File: rtl/window_range_tracker.sv
// Folds N accepted (min, max) pairs into one window result with valid/ready output.
// Optional RANGE_TRACKER_SPAN_EN builds the registered win_max - win_min span.
module window_range_tracker
    import range_tracker_pkg::*;
#(
    parameter int w = 2,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [w-1:0] in_min,
    input  logic [w-1:0] in_max,
    output logic         in_ready,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [w-1:0] win_min,
    output logic [w-1:0] win_max,
    output logic         win_err,
    output logic [w-1:0] win_span
);

    localparam int CW = cnt_width(N);

    rt_state_t     state, state_nxt;
    logic [CW-1:0] cnt;
    logic [w-1:0]  acc_min, acc_max, mrg_min, mrg_max;
    logic          acc_err, pair_err, err_nxt, first, last, accept;

    assign first  = cnt == '0;
    assign last   = cnt == CW'(N - 1);
    assign accept = in_valid && in_ready;
    assign err_nxt = first ? pair_err : (acc_err | pair_err);

    mm_merge #(.w(w)) u_merge (
        .acc_min (acc_min),
        .acc_max (acc_max),
        .in_min  (in_min),
        .in_max  (in_max),
        .first   (first),
        .mrg_min (mrg_min),
        .mrg_max (mrg_max),
        .pair_err(pair_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_ACCUM;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCUM: if (accept && last) state_nxt = ST_HOLD;
            ST_HOLD:  if (out_ready)      state_nxt = ST_ACCUM;
            default:                      state_nxt = ST_ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = rst && (state == ST_ACCUM);
        out_valid = state == ST_HOLD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            acc_min <= '0;
            acc_max <= '0;
            acc_err <= 1'b0;
            win_min <= '0;
            win_max <= '0;
            win_err <= 1'b0;
        end else if (accept) begin
            acc_min <= mrg_min;
            acc_max <= mrg_max;
            acc_err <= err_nxt;
            if (last) begin
                cnt     <= '0;
                win_min <= mrg_min;
                win_max <= mrg_max;
                win_err <= err_nxt;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef RANGE_TRACKER_SPAN_EN
    // Wraps modulo 2^w; only meaningful when win_err is clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 win_span <= '0;
        else if (accept && last)  win_span <= mrg_max - mrg_min;
    end
`else
    assign win_span = '0;
`endif

endmodule

// File: tb/tb_window_range_tracker.sv
// Directed bench for window_range_tracker; a queue-based window model is checked every cycle.
module tb_window_range_tracker;
    localparam int W = 2;
    localparam int N = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_min = '0;
    logic [W-1:0] in_max = '0;
    logic         in_ready;
    logic         out_ready = 1'b1;
    logic         out_valid;
    logic [W-1:0] win_min, win_max, win_span;
    logic         win_err;

    int total = 0;
    int bad = 0;

    window_range_tracker #(.w(W), .N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_min(in_min), .in_max(in_max),
        .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
        .win_min(win_min), .win_max(win_max), .win_err(win_err), .win_span(win_span)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: collect accepted pairs; when N are held, fold them into a result.
    int q_min[$];
    int q_max[$];
    bit m_hold;
    int m_min, m_max, m_err, m_span;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_min.delete();
            q_max.delete();
            m_hold = 0;
            m_min = 0; m_max = 0; m_err = 0; m_span = 0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 0;
        end else if (in_valid) begin
            q_min.push_back(int'(in_min));
            q_max.push_back(int'(in_max));
            if (q_min.size() == N) begin
                m_min = MASK; m_max = 0; m_err = 0;
                for (int i = 0; i < N; i++) begin
                    if (q_min[i] < m_min) m_min = q_min[i];
                    if (q_max[i] > m_max) m_max = q_max[i];
                    if (q_min[i] > q_max[i]) m_err = 1;
                end
`ifdef RANGE_TRACKER_SPAN_EN
                m_span = (m_max - m_min) & MASK;
`else
                m_span = 0;
`endif
                q_min.delete();
                q_max.delete();
                m_hold = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", int'(out_valid), int'(m_hold));
        chk("in_ready", int'(in_ready), int'(rst && !m_hold));
        chk("win_min", int'(win_min), m_min);
        chk("win_max", int'(win_max), m_max);
        chk("win_err", int'(win_err), m_err);
        chk("win_span", int'(win_span), m_span);
    end

    task automatic push(input int mn, input int mx);
        in_valid = 1'b1;
        in_min = W'(mn);
        in_max = W'(mx);
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        chk("push_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            if (out_valid) return;
            @(negedge clk);
        end
        chk("valid_timeout", 0, 1);
    endtask

    task automatic lit(input string name, input int mn, input int mx, input int er);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_min"}, int'(win_min), mn);
        chk({name, "_max"}, int'(win_max), mx);
        chk({name, "_err"}, int'(win_err), er);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_valid", int'(out_valid), 0);
        #2 rst = 1'b1;
        @(negedge clk);

        // Basic window, in_valid held high
        push(1, 2); push(0, 3); push(2, 2); push(1, 1);
        lit("basic", 0, 3, 0);
`ifdef RANGE_TRACKER_SPAN_EN
        chk("basic_span", int'(win_span), 3);
`else
        chk("basic_span", int'(win_span), 0);
`endif
        in_valid = 1'b0;
        @(negedge clk);
        chk("basic_drop", int'(out_valid), 0);
        chk("basic_ready", int'(in_ready), 1);

        // Backpressure: offered (3,0) pairs during hold must not be consumed
        out_ready = 1'b0;
        push(2, 3); push(1, 1); push(3, 3); push(0, 2);
        push_hold: begin
            in_min = 2'd3; in_max = 2'd0;
            repeat (5) @(negedge clk);
        end
        lit("bp", 0, 3, 0);
        chk("bp_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        push(1, 1); push(1, 1); push(1, 1); push(1, 1);
        in_valid = 1'b0;
        lit("bp_next", 1, 1, 0);
        @(negedge clk);

        // Gaps: valid pattern 1,0,0,1,1,0,1; idle cycles carry (0,0)
        in_valid = 1'b1; in_min = 2'd2; in_max = 2'd3; @(negedge clk);
        in_valid = 1'b0; in_min = 2'd0; in_max = 2'd0; @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1; in_min = 2'd1; in_max = 2'd2; @(negedge clk);
        in_min = 2'd3; in_max = 2'd3; @(negedge clk);
        in_valid = 1'b0; in_min = 2'd0; in_max = 2'd0;
        chk("gap_early", int'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b1; in_min = 2'd2; in_max = 2'd2; @(negedge clk);
        in_valid = 1'b0;
        lit("gap", 1, 3, 0);
        @(negedge clk);

        // Error window, then a clean one clears the flag
        push(3, 1); push(0, 0); push(1, 2); push(0, 1);
        in_valid = 1'b0;
        lit("err", 0, 2, 1);
        @(negedge clk);
        push(1, 2); push(2, 3); push(1, 1); push(2, 2);
        in_valid = 1'b0;
        lit("clean", 1, 3, 0);
        @(negedge clk);

        // Reset mid-window discards the partial window
        push(3, 3); push(3, 3);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1 chk("midrst_ready", int'(in_ready), 0);
        chk("midrst_max", int'(win_max), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        push(1, 1); push(1, 1); push(1, 1); push(1, 1);
        in_valid = 1'b0;
        lit("midrst", 1, 1, 0);
        @(negedge clk);

        // Reset while holding a result drops out_valid at once
        out_ready = 1'b0;
        push(0, 3); push(1, 1); push(2, 2); push(1, 2);
        in_valid = 1'b0;
        wait_valid();
        lit("hold", 0, 3, 0);
        #2 rst = 1'b0;
        #1 chk("holdrst_valid", int'(out_valid), 0);
        chk("holdrst_ready", int'(in_ready), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
